// File: rtl/spike_rate_decoder_if.sv
// Spike-train input and decoded-result output bundle for spike_rate_decoder.
// master = decoder side, slave = spike source / result consumer side.
interface spike_rate_decoder_if #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 10
);
    logic             spike;
    logic             enable;
    logic [WIN_W-1:0] window;
    logic [CNT_W-1:0] rate;
    logic [WIN_W-1:0] first_spike;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             clear_overrun;

    modport master (
        input  spike, enable, window, out_ready, clear_overrun,
        output rate, first_spike, out_valid, overrun
    );

    modport slave (
        output spike, enable, window, out_ready, clear_overrun,
        input  rate, first_spike, out_valid, overrun
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes and time-to-first-spike over a programmable window; result one cycle after the last sample.
// One-entry output register: a result arriving while the held one is unconsumed is dropped and sets overrun.
module spike_rate_decoder #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spike_rate_decoder_if.master  bus
);
    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [WIN_W-1:0] NO_SPIKE = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nx;
    logic [WIN_W-1:0] len, len_nx;
    logic [WIN_W-1:0] idx, idx_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIN_W-1:0] first, first_nx;
    logic             res_vld;

    logic [CNT_W-1:0] rate_q;
    logic [WIN_W-1:0] first_q;
    logic             valid_q;
    logic             overrun_q;

    logic [WIN_W-1:0] win_len;
    logic             last;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIN_W-1:0] first_upd;

    assign win_len   = (bus.window == '0) ? WIN_W'(1) : bus.window;
    assign last      = (idx == len - WIN_W'(1));
    // Values including this cycle's spike; they feed both the running state and the result.
    assign cnt_inc   = (bus.spike && cnt != CNT_MAX) ? cnt + CNT_W'(1) : cnt;
    assign first_upd = (bus.spike && first == NO_SPIKE) ? idx : first;

    always_comb begin
        state_nx = state;
        len_nx   = len;
        idx_nx   = idx;
        cnt_nx   = cnt;
        first_nx = first;
        res_vld  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    len_nx   = win_len;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                    first_nx = NO_SPIKE;
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                if (last) begin
                    res_vld = 1'b1;
                    if (bus.enable) begin
                        len_nx   = win_len;
                        idx_nx   = '0;
                        cnt_nx   = '0;
                        first_nx = NO_SPIKE;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (!bus.enable) begin
                    state_nx = IDLE;
                end else begin
                    idx_nx   = idx + WIN_W'(1);
                    cnt_nx   = cnt_inc;
                    first_nx = first_upd;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            cnt       <= '0;
            first     <= '0;
            rate_q    <= '0;
            first_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state <= state_nx;
            len   <= len_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            first <= first_nx;

            if (res_vld && (!valid_q || bus.out_ready)) begin
                rate_q  <= cnt_inc;
                first_q <= first_upd;
                valid_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (res_vld && valid_q && !bus.out_ready)
                overrun_q <= 1'b1;
            else if (bus.clear_overrun)
                overrun_q <= 1'b0;
        end
    end

    assign bus.rate        = rate_q;
    assign bus.first_spike = first_q;
    assign bus.out_valid   = valid_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;
    localparam int CNT_W = 8;
    localparam int WIN_W = 10;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int NO_SPIKE = (1 << WIN_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spike_rate_decoder_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    spike_rate_decoder #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, obs, exp);
        end
    endtask

    // Reference: a window is a list of sampled cycles; spikes are tallied without saturation
    // and clipped only when the result is formed.
    bit m_busy;
    int m_len, m_pos, m_count, m_first;
    bit m_valid, m_ovr;
    int m_rate, m_fs;

    function automatic void m_start(input int win);
        m_busy  = 1;
        m_len   = (win == 0) ? 1 : win;
        m_pos   = 0;
        m_count = 0;
        m_first = -1;
    endfunction

    function automatic void model_step(input bit rstn, input bit spk, input bit en,
                                       input int win, input bit rdy, input bit clr);
        bit new_res = 0;
        int n_rate = 0, n_fs = 0;
        bit drop = 0;
        if (!rstn) begin
            m_busy = 0; m_valid = 0; m_ovr = 0; m_rate = 0; m_fs = 0;
            return;
        end
        if (m_busy) begin
            if (!en && m_pos != m_len - 1) begin
                m_busy = 0;
            end else begin
                if (spk) begin
                    m_count++;
                    if (m_first < 0) m_first = m_pos;
                end
                if (m_pos == m_len - 1) begin
                    new_res = 1;
                    n_rate  = (m_count > CNT_MAX) ? CNT_MAX : m_count;
                    n_fs    = (m_first < 0) ? NO_SPIKE : m_first;
                    if (en) m_start(win);
                    else    m_busy = 0;
                end else begin
                    m_pos++;
                end
            end
        end else if (en) begin
            m_start(win);
        end
        if (new_res) begin
            if (!m_valid || rdy) begin
                m_rate = n_rate; m_fs = n_fs; m_valid = 1;
            end else begin
                drop = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (drop)      m_ovr = 1;
        else if (clr)  m_ovr = 0;
    endfunction

    typedef struct {
        int cycles;
        int win_lo, win_hi;
        int spk_pct, en_pct, rdy_pct, clr_pct, rst_pct;
    } phase_t;

    phase_t phases[6] = '{
        '{400,  10,  10,  30, 100, 100,  0, 0},
        '{300,   0,   0, 100, 100, 100,  0, 0},
        '{400,   4,   4,   0, 100, 100,  0, 0},
        '{1500, 300, 300, 100, 100, 100,  0, 0},
        '{800,   5,   5,  50, 100,  20, 10, 0},
        '{3000,  0,  12,  50,  95,  60,  5, 1}
    };

    task automatic drive_and_check(input bit rstn, input bit spk, input bit en, input int win,
                                   input bit rdy, input bit clr);
        rst_n             = rstn;
        bus.spike         = spk;
        bus.enable        = en;
        bus.window        = WIN_W'(win);
        bus.out_ready     = rdy;
        bus.clear_overrun = clr;
        model_step(rstn, spk, en, win, rdy, clr);
        @(negedge clk);
        cycle++;
        check("out_valid",   32'(bus.out_valid),   32'(m_valid));
        check("rate",        32'(bus.rate),        32'(m_rate));
        check("first_spike", 32'(bus.first_spike), 32'(m_fs));
        check("overrun",     32'(bus.overrun),     32'(m_ovr));
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            drive_and_check(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        foreach (phases[p]) begin
            for (int c = 0; c < phases[p].cycles; c++) begin
                bit rstn, spk, en, rdy, clr;
                int win;
                rstn = ($urandom_range(99) >= phases[p].rst_pct);
                spk  = ($urandom_range(99) <  phases[p].spk_pct);
                en   = ($urandom_range(99) <  phases[p].en_pct);
                rdy  = ($urandom_range(99) <  phases[p].rdy_pct);
                clr  = ($urandom_range(99) <  phases[p].clr_pct);
                win  = $urandom_range(phases[p].win_hi, phases[p].win_lo);
                drive_and_check(rstn, spk, en, win, rdy, clr);
            end
            // Drain between phases so each starts from an idle, empty decoder.
            for (int i = 0; i < 2; i++)
                drive_and_check(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
